// File: rtl/sa_result_drain.sv
// Snapshots the flattened array result bus on a capture strobe and streams it out one element per handshake.
// Latency: capture at edge t presents element 0 from edge t+1; then up to one element per cycle.
// Backpressure: outputs hold while o_out_valid & !i_out_ready; a capture arriving mid-stream is dropped and flagged sticky.
module sa_result_drain #(
   parameter int WIDTH = 8,
   parameter int HPE   = 4,
   parameter int VPE   = 4,
   localparam int RW   = (VPE > 1) ? $clog2(VPE) : 1,
   localparam int CW   = (HPE > 1) ? $clog2(HPE) : 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [2*WIDTH*HPE*VPE-1:0]  i_y_in,
   input  logic                        i_cap,
   output logic                        o_busy,
   output logic                        o_out_valid,
   input  logic                        i_out_ready,
   output logic [2*WIDTH-1:0]          o_out_data,
   output logic [RW-1:0]               o_out_row,
   output logic [CW-1:0]               o_out_col,
   output logic                        o_out_last,
   output logic                        o_overrun
);

   localparam int N  = HPE * VPE;
   localparam int EW = 2 * WIDTH;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
   localparam logic [CW-1:0] COL_MAX  = CW'(HPE - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t              r_state;
   logic [N*EW-1:0]     r_shadow;
   logic [IW-1:0]       r_idx;
   logic [EW-1:0]       r_data;
   logic [RW-1:0]       r_row;
   logic [CW-1:0]       r_col;
   logic                r_last;
   logic                r_valid;
   logic                r_busy;
   logic                r_overrun;

   logic [IW-1:0]       w_idx_nxt;
   logic [EW-1:0]       w_dat_nxt;
   logic [EW-1:0]       w_y_first;
   logic                w_xfer;

   assign w_y_first = i_y_in[N*EW-1 -: EW];
   assign w_xfer    = r_valid & i_out_ready;

   // Next element index and its data, selected from the shadow copy only
   always_comb begin
      w_idx_nxt = r_idx + IW'(1);
      w_dat_nxt = '0;
      for (int k = 0; k < N; k++) begin
         if (w_idx_nxt == IW'(k)) begin
            w_dat_nxt = r_shadow[(N-k)*EW-1 -: EW];
         end
      end
   end

   // Capture/stream FSM with all outputs registered; reset beats a same-edge capture
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state   <= IDLE;
         r_shadow  <= '0;
         r_idx     <= '0;
         r_data    <= '0;
         r_row     <= '0;
         r_col     <= '0;
         r_last    <= 1'b0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_cap) begin
                  r_state  <= STREAM;
                  r_shadow <= i_y_in;
                  r_idx    <= '0;
                  r_data   <= w_y_first;
                  r_row    <= '0;
                  r_col    <= '0;
                  r_last   <= (LAST_IDX == '0);
                  r_valid  <= 1'b1;
                  r_busy   <= 1'b1;
               end
            end
            STREAM: begin
               if (w_xfer && r_last) begin
                  // Final element leaves; a capture on this very edge restarts with no bubble
                  if (i_cap) begin
                     r_shadow <= i_y_in;
                     r_idx    <= '0;
                     r_data   <= w_y_first;
                     r_row    <= '0;
                     r_col    <= '0;
                     r_last   <= (LAST_IDX == '0);
                  end else begin
                     r_state  <= IDLE;
                     r_valid  <= 1'b0;
                     r_busy   <= 1'b0;
                     r_last   <= 1'b0;
                  end
               end else begin
                  if (i_cap) begin
                     r_overrun <= 1'b1;
                  end
                  if (w_xfer) begin
                     r_idx  <= w_idx_nxt;
                     r_data <= w_dat_nxt;
                     r_last <= (w_idx_nxt == LAST_IDX);
                     if (r_col == COL_MAX) begin
                        r_col <= '0;
                        r_row <= r_row + RW'(1);
                     end else begin
                        r_col <= r_col + CW'(1);
                     end
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_out_valid = r_valid;
   assign o_out_data  = r_data;
   assign o_out_row   = r_row;
   assign o_out_col   = r_col;
   assign o_out_last  = r_last;
   assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_sa_result_drain.sv
// Bench for sa_result_drain with a 2x2 grid of 16-bit results.
// A posedge reference model pushes expected elements per accepted capture; a negedge monitor checks every cycle.
// Directed scenarios cover drain, stall, isolation, overrun, back-to-back and reset, then random traffic.
module tb_sa_result_drain;

   localparam int WIDTH = 8;
   localparam int HPE   = 2;
   localparam int VPE   = 2;
   localparam int N     = HPE * VPE;
   localparam int EW    = 2 * WIDTH;

   typedef struct packed {
      logic [EW-1:0] d;
      logic          r;
      logic          c;
      logic          l;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [N*EW-1:0]  y_in;
   logic             cap;
   logic             ready;
   logic             busy;
   logic             valid;
   logic [EW-1:0]    data;
   logic             row;
   logic             col;
   logic             last;
   logic             overrun;

   exp_t exp_q[$];
   int   remaining;
   logic m_ovr;
   int   errors;
   int   checks;

   sa_result_drain #(.WIDTH(WIDTH), .HPE(HPE), .VPE(VPE)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_y_in      (y_in),
      .i_cap       (cap),
      .o_busy      (busy),
      .o_out_valid (valid),
      .i_out_ready (ready),
      .o_out_data  (data),
      .o_out_row   (row),
      .o_out_col   (col),
      .o_out_last  (last),
      .o_overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a stream is a list of N elements cut from the snapshot, row-major, element 0 in the MSBs
   always @(posedge clk) begin
      logic xfer;
      logic fin;
      logic [N*EW-1:0] sh;
      exp_t e;
      if (!rst) begin
         exp_q.delete();
         remaining = 0;
         m_ovr = 1'b0;
      end else begin
         xfer = (remaining > 0) && ready;
         fin  = xfer && (remaining == 1);
         if (xfer) remaining = remaining - 1;
         if (cap) begin
            if (remaining == 0 || fin) begin
               for (int k = 0; k < N; k++) begin
                  sh  = y_in >> ((N - 1 - k) * EW);
                  e.d = sh[EW-1:0];
                  e.r = 1'((k / HPE));
                  e.c = 1'((k % HPE));
                  e.l = (k == N - 1);
                  exp_q.push_back(e);
               end
               remaining = remaining + N;
            end else begin
               m_ovr = 1'b1;
            end
         end
      end
   end

   // Monitor: every cycle compare flags; whenever an element is presented compare it to the queue head
   always @(negedge clk) begin
      exp_t e;
      checks++;
      if (valid !== (remaining > 0) || busy !== (remaining > 0)) begin
         errors++;
         $display("FAIL valid_busy t=%0t got valid=%b busy=%b want %b", $time, valid, busy, remaining > 0);
      end
      checks++;
      if (overrun !== m_ovr) begin
         errors++;
         $display("FAIL overrun t=%0t got %b want %b", $time, overrun, m_ovr);
      end
      if (valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_elem t=%0t got data=%h with nothing expected", $time, data);
         end else begin
            e = exp_q[0];
            if (data !== e.d || row !== e.r || col !== e.c || last !== e.l) begin
               errors++;
               $display("FAIL elem t=%0t got %h(%0d,%0d) last=%b want %h(%0d,%0d) last=%b",
                        $time, data, row, col, last, e.d, e.r, e.c, e.l);
            end
            if (ready && rst) void'(exp_q.pop_front());
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      remaining = 0;
      m_ovr = 1'b0;
      rst   = 1'b0;
      cap   = 1'b0;
      ready = 1'b0;
      y_in  = 64'h1111_2222_3333_4444;
      step(2);
      checks++;
      if (data !== '0 || row !== 1'b0 || col !== 1'b0 || last !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got data=%h row=%b col=%b last=%b want zeros", data, row, col, last);
      end
      rst = 1'b1;
      step(1);

      // Basic drain at full rate
      ready = 1'b1;
      cap = 1'b1; step(1); cap = 1'b0;
      step(6);

      // Backpressure while 2222 is presented
      cap = 1'b1; step(1); cap = 1'b0;
      step(1);
      ready = 1'b0; step(3);
      ready = 1'b1; step(5);

      // Snapshot isolation
      cap = 1'b1; step(1); cap = 1'b0;
      y_in = 64'hAAAA_BBBB_CCCC_DDDD;
      step(6);
      y_in = 64'h1111_2222_3333_4444;

      // Overrun during 2222, then capture on the final transfer
      cap = 1'b1; step(1); cap = 1'b0;
      step(1);
      cap = 1'b1; step(1); cap = 1'b0;
      step(1);
      y_in = 64'hAAAA_BBBB_CCCC_DDDD;
      cap = 1'b1; step(1); cap = 1'b0;
      step(6);
      y_in = 64'h1111_2222_3333_4444;

      // Reset while 3333 is presented, then restart
      cap = 1'b1; step(1); cap = 1'b0;
      step(2);
      rst = 1'b0; step(1); rst = 1'b1;
      step(2);
      cap = 1'b1; step(1); cap = 1'b0;
      step(6);

      // Reset beats a same-edge capture
      rst = 1'b0; cap = 1'b1; step(1);
      rst = 1'b1; cap = 1'b0;
      step(3);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         ready = ($urandom_range(0, 3) != 0);
         cap   = ($urandom_range(0, 7) == 0);
         rst   = ($urandom_range(0, 99) != 0);
         y_in  = {$urandom, $urandom};
         step(1);
      end
      rst = 1'b1; cap = 1'b0; ready = 1'b1;
      step(N + 4);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_empty got %0d leftover elements want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sa_result_drain.md
Name: sa_result_drain

Overview:
- Output-side companion to the systolic-array top (ports AA, BB, CLK, RST, Y).
- Snapshots the flattened accumulator bus Y on a capture strobe and streams its HPE*VPE results out one element per handshake, with row/column tags.
- Sits between the array's Y output and the result sink: an on-chip buffer, a checker, or the bench scoreboard.
- Replaces direct sampling of the wide Y bus, so results can be drained under backpressure while the array keeps running.

Parameters:
- WIDTH, 8, operand width; each result element is 2*WIDTH bits.
- HPE, 4, PEs per row (column count of the result grid).
- VPE, 4, PE rows (row count of the result grid).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous active-low reset.
- Y_IN  input  2*WIDTH*HPE*VPE  flattened array result bus, same packing as the array's Y.
- CAP  input  1  capture strobe, one-cycle pulse.
- BUSY  output  1  high while a snapshot is being drained.
- OUT_VALID  output  1  OUT_DATA/OUT_ROW/OUT_COL/OUT_LAST are valid.
- OUT_READY  input  1  sink accepts the current element.
- OUT_DATA  output  2*WIDTH  result element.
- OUT_ROW  output  max(1,clog2(VPE))  row index r.
- OUT_COL  output  max(1,clog2(HPE))  column index c.
- OUT_LAST  output  1  high with the final element (r=VPE-1, c=HPE-1).
- OVERRUN  output  1  sticky flag: a CAP was dropped.

Behaviour:
- Reset (RST=0 at a rising edge) is synchronous and active-low. It sets all outputs and the index to 0, sets the state to IDLE, and clears the shadow register. It takes effect mid-stream: the stream is aborted with no further element, and OVERRUN is cleared.
- Element packing: e = r*HPE + c. Element e occupies Y_IN[(HPE*VPE-e)*2*WIDTH-1 -: 2*WIDTH], so element 0 sits in the MSBs.
- Stream order: row-major, e = 0 .. HPE*VPE-1.
- IDLE state:
  - BUSY=0, OUT_VALID=0.
  - CAP=1 latches all of Y_IN into the shadow register, sets e=0 and moves to STREAM.
- Capture latency: CAP high at edge t gives OUT_VALID=1 from edge t+1, with element 0 presented.
- STREAM state:
  - BUSY=1, OUT_VALID=1.
  - Outputs come from registers, driven from the shadow register only. Y_IN changes after capture have no effect.
- Handshake:
  - A transfer occurs on any edge with OUT_VALID & OUT_READY.
  - With OUT_READY=0, OUT_DATA/ROW/COL/LAST hold stable and OUT_VALID stays high. There is no valid retraction.
  - A transfer with e < HPE*VPE-1 advances to e+1. OUT_COL wraps to 0 and OUT_ROW increments at c = HPE-1.
  - A transfer with OUT_LAST=1 returns to IDLE, with OUT_VALID=0 the next cycle, unless a same-edge CAP is accepted (next bullet).
  - Peak throughput is one element per cycle when OUT_READY is held high.
- CAP rules:
  - CAP on the same edge as the final transfer is accepted: a new snapshot is taken, e=0, and OUT_VALID stays 1 with no bubble.
  - CAP in STREAM at any other edge is ignored, the current stream is unaffected, and OVERRUN is set to 1 and stays set until reset.
- Simultaneous RST=0 and CAP: reset wins, and the state goes to IDLE with no snapshot.
- Storage is one shadow register of 2*WIDTH*HPE*VPE bits plus an element index, with no FIFO.

Test Plan (WIDTH=8, HPE=VPE=2; Y_IN=64'h1111_2222_3333_4444 unless stated):
- Basic drain: OUT_READY=1, CAP pulse at edge t → OUT_VALID rises at t+1; elements 1111(0,0), 2222(0,1), 3333(1,0), 4444(1,1) on consecutive cycles; OUT_LAST only on 4444; BUSY low at t+5.
- Backpressure: OUT_READY=0 for 3 cycles while 2222 is presented → 2222/(0,1) held stable, OUT_VALID stays 1; raising OUT_READY resumes with 3333.
- Snapshot isolation: change Y_IN to 64'hAAAA_BBBB_CCCC_DDDD one cycle after CAP → the stream still emits 1111..4444.
- Overrun and back-to-back:
  - CAP during the 2222 element → ignored, OVERRUN=1 and sticky.
  - CAP coinciding with the 4444 transfer, Y_IN=AAAA.. → next cycle OUT_VALID=1 with AAAA(0,0), no gap.
- Reset mid-stream: RST=0 while 3333 is presented → next cycle OUT_VALID=0, BUSY=0, OVERRUN=0; a later CAP restarts at (0,0).
- Reset priority: RST=0 and CAP on the same edge → IDLE, no output.
